// File: rtl/sign_ex_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : sign_ex_pkg                                               |
// | Purpose  : Shared constants for the operand extension unit:          |
// |            ext_op encodings and the fixed input/output widths.       |
// | Ports    : none (package)                                            |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
package sign_ex_pkg;

    localparam int IN_W  = 16;
    localparam int OUT_W = 32;

    // ext_op encodings; 3'b110 and 3'b111 are reserved.
    localparam logic [2:0] EXT_SEXT16 = 3'b000;
    localparam logic [2:0] EXT_ZEXT16 = 3'b001;
    localparam logic [2:0] EXT_LUI    = 3'b010;
    localparam logic [2:0] EXT_SEXT8  = 3'b011;
    localparam logic [2:0] EXT_ZEXT8  = 3'b100;
    localparam logic [2:0] EXT_BRANCH = 3'b101;

endpackage : sign_ex_pkg
`default_nettype wire

// File: rtl/sign_ex_comb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : sign_ex_comb                                              |
// | Purpose  : Purely combinational 16->32 bit extension function.       |
// | Ports    : wirein  [15:0] in  - value to extend                      |
// |            ext_op  [2:0]  in  - extension mode                       |
// |            ext_val [31:0] out - extended value                       |
// |            illegal        out - ext_op is a reserved encoding        |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module sign_ex_comb
    import sign_ex_pkg::*;
(
    input  logic [IN_W-1:0]  wirein,
    input  logic [2:0]       ext_op,
    output logic [OUT_W-1:0] ext_val,
    output logic             illegal
);

    always_comb begin
        // Reserved encodings fall back to the SEXT16 result.
        ext_val = {{16{wirein[15]}}, wirein};
        illegal = 1'b0;
        case (ext_op)
            EXT_SEXT16: ext_val = {{16{wirein[15]}}, wirein};
            EXT_ZEXT16: ext_val = {16'h0000, wirein};
            EXT_LUI:    ext_val = {wirein, 16'h0000};
            EXT_SEXT8:  ext_val = {{24{wirein[7]}}, wirein[7:0]};
            EXT_ZEXT8:  ext_val = {24'h000000, wirein[7:0]};
            // Sign-extend then shift left by 2; the top two sign bits fall off.
            EXT_BRANCH: ext_val = {{14{wirein[15]}}, wirein, 2'b00};
            default:    illegal = 1'b1;
        endcase
    end

endmodule : sign_ex_comb
`default_nettype wire

// File: rtl/sign_ex.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : sign_ex                                                   |
// | Purpose  : Registered immediate / load-data extension unit.          |
// |            One-cycle latency, one result per cycle.                  |
// | Ports    : clk            in  - system clock (rising edge)           |
// |            rst_n          in  - synchronous active-low reset         |
// |            wirein  [15:0] in  - value to extend                      |
// |            ext_op  [2:0]  in  - extension mode                       |
// |            in_valid       in  - qualifies wirein / ext_op            |
// |            wireout [31:0] out - registered extended result           |
// |            out_valid      out - wireout loaded on the previous edge  |
// |            op_err         out - last accepted ext_op was reserved    |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module sign_ex
    import sign_ex_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IN_W-1:0]  wirein,
    input  logic [2:0]       ext_op,
    input  logic             in_valid,
    output logic [OUT_W-1:0] wireout,
    output logic             out_valid,
    output logic             op_err
);

    logic [OUT_W-1:0] w_ext_val;
    logic             w_illegal;

    logic [OUT_W-1:0] r_wireout;
    logic             r_out_valid;
    logic             r_op_err;

    sign_ex_comb u_comb (
        .wirein  (wirein),
        .ext_op  (ext_op),
        .ext_val (w_ext_val),
        .illegal (w_illegal)
    );

    // Reset wins over in_valid, so a result in flight at a reset edge is dropped.
    // Idle cycles keep the last result and error flag; only out_valid drops.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wireout   <= '0;
            r_out_valid <= 1'b0;
            r_op_err    <= 1'b0;
        end else if (in_valid) begin
            r_wireout   <= w_ext_val;
            r_out_valid <= 1'b1;
            r_op_err    <= w_illegal;
        end else begin
            r_out_valid <= 1'b0;
        end
    end

    assign wireout   = r_wireout;
    assign out_valid = r_out_valid;
    assign op_err    = r_op_err;

endmodule : sign_ex
`default_nettype wire

// File: tb/tb_sign_ex.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_sign_ex                                                |
// | Purpose  : Scoreboard bench for sign_ex with directed vectors.       |
// | Ports    : none                                                      |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module tb_sign_ex;

    logic        clk;
    logic        rst_n;
    logic [15:0] wirein;
    logic [2:0]  ext_op;
    logic        in_valid;
    logic [31:0] wireout;
    logic        out_valid;
    logic        op_err;

    sign_ex dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wirein    (wirein),
        .ext_op    (ext_op),
        .in_valid  (in_valid),
        .wireout   (wireout),
        .out_valid (out_valid),
        .op_err    (op_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        vld;
        logic [31:0] data;
        logic        err;
        int          tag;
    } exp_t;

    exp_t        q[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          vec      = 0;
    logic        h_vld    = 1'b0;
    logic [31:0] h_data   = 32'h0;
    logic        h_err    = 1'b0;

    task automatic chk(input string name, input int tag,
                       input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s (vector %0d): got %h, required %h", name, tag, act, exp);
    endtask

    // One stimulus cycle. ed/ee are the hand-computed result for an accepted
    // input; the expected register state for every cycle is queued.
    task automatic cyc(input logic r, input logic v, input logic [2:0] op,
                       input logic [15:0] w, input logic [31:0] ed, input logic ee);
        exp_t e;
        @(negedge clk);
        rst_n    = r;
        in_valid = v;
        ext_op   = op;
        wirein   = w;
        if (!r) begin
            h_vld = 1'b0; h_data = 32'h0; h_err = 1'b0;
        end else if (v) begin
            h_vld = 1'b1; h_data = ed; h_err = ee;
        end else begin
            h_vld = 1'b0;
        end
        e.vld = h_vld; e.data = h_data; e.err = h_err; e.tag = vec;
        q.push_back(e);
        vec++;
    endtask

    // Monitor: one queued expectation per clock edge, checked 1 time unit after it.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("out_valid", e.tag, {31'b0, out_valid}, {31'b0, e.vld});
                chk("wireout",   e.tag, wireout, e.data);
                chk("op_err",    e.tag, {31'b0, op_err}, {31'b0, e.err});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b1; ext_op = 3'b011; wirein = 16'hBEEF;

        // Reset held two cycles with arbitrary inputs
        cyc(0, 1, 3'b101, 16'hFFFF, 32'h0, 0);
        cyc(0, 1, 3'b010, 16'h1234, 32'h0, 0);

        // Basic sign-extend; first is accepted on the reset-release edge
        cyc(1, 1, 3'b000, 16'h0000, 32'h00000000, 0);
        cyc(1, 1, 3'b000, 16'hA4AA, 32'hFFFFA4AA, 0);

        // Mode sweep, back-to-back
        cyc(1, 1, 3'b001, 16'hA4AA, 32'h0000A4AA, 0);
        cyc(1, 1, 3'b010, 16'hA4AA, 32'hA4AA0000, 0);
        cyc(1, 1, 3'b011, 16'hA4AA, 32'hFFFFFFAA, 0);
        cyc(1, 1, 3'b100, 16'hA4AA, 32'h000000AA, 0);
        cyc(1, 1, 3'b101, 16'hA4AA, 32'hFFFE92A8, 0);

        // Boundaries
        cyc(1, 1, 3'b000, 16'h7FFF, 32'h00007FFF, 0);
        cyc(1, 1, 3'b000, 16'h8000, 32'hFFFF8000, 0);
        cyc(1, 1, 3'b011, 16'h007F, 32'h0000007F, 0);
        cyc(1, 1, 3'b011, 16'h7F80, 32'hFFFFFF80, 0);
        cyc(1, 1, 3'b100, 16'hFF12, 32'h00000012, 0);
        cyc(1, 1, 3'b101, 16'h7FFF, 32'h0001FFFC, 0);
        cyc(1, 1, 3'b101, 16'h8000, 32'hFFFE0000, 0);
        cyc(1, 1, 3'b001, 16'hFFFF, 32'h0000FFFF, 0);

        // Reserved op then hold for 3 idle cycles
        cyc(1, 1, 3'b111, 16'h8001, 32'hFFFF8001, 1);
        cyc(1, 0, 3'b000, 16'h0000, 32'h0, 0);
        cyc(1, 0, 3'b001, 16'h1111, 32'h0, 0);
        cyc(1, 0, 3'b010, 16'h2222, 32'h0, 0);

        // Other reserved code, then a legal op clears the error
        cyc(1, 1, 3'b110, 16'h0001, 32'h00000001, 1);
        cyc(1, 1, 3'b010, 16'h0001, 32'h00010000, 0);

        // Mid-stream reset: the input presented at the reset edge is discarded
        cyc(1, 1, 3'b000, 16'h1234, 32'h00001234, 0);
        cyc(0, 1, 3'b001, 16'h5555, 32'h0, 0);
        cyc(1, 1, 3'b010, 16'h00FF, 32'h00FF0000, 0);
        cyc(1, 1, 3'b011, 16'h0080, 32'hFFFFFF80, 0);
        cyc(1, 0, 3'b000, 16'h0000, 32'h0, 0);

        repeat (3) @(negedge clk);
        chk("queue drained", -1, q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_sign_ex
`default_nettype wire
